// File: rtl/sdram_sched_pkg.sv
// Shared types and defaults for the SDRAM burst scheduler.
//   sched_state_t : scheduler FSM states (IDLE, REQ, WAIT)
//   CMD_WR/CMD_RD : values carried on cmd_wr and in last_grant
//   *_DEF         : default address, burst-length and FIFO-level widths
package sdram_sched_pkg;

  localparam int ADDR_W_DEF = 22;   // {bank[1:0], 20-bit offset}
  localparam int LEN_W_DEF  = 9;    // burst length up to 256
  localparam int LVL_W_DEF  = 10;   // FIFO used-words

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } sched_state_t;

endpackage

// File: rtl/sdram_addr_gen.sv
// Per-direction burst address pointer.
// Tracks the start address while SDRAM init is pending, reloads it on
// load, and otherwise advances by the burst length at the end of each
// burst, wrapping to the start address at the (exclusive) frame limit.
// Ports:
//   clk_ref, rst      : clock, synchronous active-high reset
//   track             : follow start_addr every cycle (init not done)
//   load              : reload pointer to start_addr (beats advance)
//   advance           : burst finished, step the pointer
//   start_addr        : frame start address
//   max_addr          : frame end address (exclusive)
//   len               : burst length used for the step
//   ptr               : current burst address
//   frame_done        : one-cycle pulse when the pointer wraps
module sdram_addr_gen #(
  parameter int ADDR_W = 22,
  parameter int LEN_W  = 9
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              track,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] max_addr,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] ptr,
  output logic              frame_done
);

  // One extra bit so a step past the top of the address space still
  // compares correctly against max_addr.
  logic [ADDR_W:0] next_ptr;

  assign next_ptr = {1'b0, ptr} + (ADDR_W+1)'(len);

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      ptr        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (track || load) begin
        ptr <= start_addr;
      end else if (advance) begin
        if (next_ptr >= {1'b0, max_addr}) begin
          ptr        <= start_addr;
          frame_done <= 1'b1;
        end else begin
          ptr <= next_ptr[ADDR_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/sdram_burst_sched.sv
// Burst scheduler between the camera/display FIFOs and the SDRAM command
// engine. Grants one write or read burst at a time based on FIFO fill
// levels, round-robin when both directions want service, and keeps one
// wrapping address pointer per direction.
// Optional build macro: SDRAM_SCHED_WDOG_EN adds a REQ/WAIT watchdog and
// the sticky sched_err output.
// Ports:
//   clk_ref, rst                 : clock, synchronous active-high reset
//   sdram_init_done              : no grants until SDRAM init completes
//   wr_fifo_usedw/rd_fifo_usedw  : FIFO fill levels
//   rd_enable                    : display is consuming, reads allowed
//   wr_length/rd_length          : burst length per direction (0 = off)
//   wr_addr/rd_addr              : frame start addresses
//   wr_max_addr/rd_max_addr      : frame end addresses (exclusive)
//   wr_load/rd_load              : reload pointer to start address
//   cmd_req/cmd_wr/cmd_addr/cmd_len, cmd_ack, cmd_done : engine handshake
//   frame_write_done/frame_read_done : pointer wrap pulses
//   busy                         : burst outstanding (REQ or WAIT)
//   sched_err                    : watchdog fired (macro builds only)
//
// state | meaning
// IDLE  | no burst outstanding; evaluate eligibility and grant
// REQ   | request presented, cmd_* held until cmd_ack
// WAIT  | burst accepted, waiting for cmd_done
module sdram_burst_sched
  import sdram_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int LVL_W  = LVL_W_DEF
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              sdram_init_done,
  input  logic [LVL_W-1:0]  wr_fifo_usedw,
  input  logic [LVL_W-1:0]  rd_fifo_usedw,
  input  logic              rd_enable,
  input  logic [LEN_W-1:0]  wr_length,
  input  logic [LEN_W-1:0]  rd_length,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] wr_max_addr,
  input  logic [ADDR_W-1:0] rd_max_addr,
  input  logic              wr_load,
  input  logic              rd_load,
  output logic              cmd_req,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic              frame_write_done,
  output logic              frame_read_done,
  output logic              busy
`ifdef SDRAM_SCHED_WDOG_EN
  ,
  output logic              sched_err
`endif
);

  localparam int CMP_W = (LVL_W > LEN_W) ? LVL_W : LEN_W;

  sched_state_t      state;
  logic              last_grant;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CMP_W-1:0]  wr_lvl, rd_lvl, wr_len_x, rd_len_x;
  logic              wr_elig, rd_elig, grant_any, grant_wr;
  logic              burst_end, wr_adv, rd_adv;
  logic              wdog_fire;

  assign wr_lvl   = CMP_W'(wr_fifo_usedw);
  assign rd_lvl   = CMP_W'(rd_fifo_usedw);
  assign wr_len_x = CMP_W'(wr_length);
  assign rd_len_x = CMP_W'(rd_length);

  // A zero length would otherwise make the write side always eligible.
  assign wr_elig   = (wr_length != '0) && (wr_lvl >= wr_len_x);
  assign rd_elig   = rd_enable && (rd_length != '0) && (rd_lvl < rd_len_x);
  assign grant_any = sdram_init_done && (wr_elig || rd_elig);
  assign grant_wr  = wr_elig && (!rd_elig || (last_grant == CMD_RD));

  assign burst_end = (state == WAIT) && cmd_done;
  assign wr_adv    = burst_end && (cmd_wr == CMD_WR);
  assign rd_adv    = burst_end && (cmd_wr == CMD_RD);

`ifdef SDRAM_SCHED_WDOG_EN
  // Down-counter reloaded every IDLE cycle; reaching zero on the 1023rd
  // REQ/WAIT cycle abandons the burst. A handshake landing on that same
  // cycle still wins.
  localparam logic [9:0] WDOG_LOAD = 10'd1022;
  logic [9:0] wdog_cnt;

  assign wdog_fire = sdram_init_done && (state != IDLE) && (wdog_cnt == '0)
                     && !((state == REQ) && cmd_ack) && !burst_end;

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      wdog_cnt  <= WDOG_LOAD;
      sched_err <= 1'b0;
    end else begin
      if (state == IDLE) begin
        wdog_cnt <= WDOG_LOAD;
      end else if (wdog_cnt != '0) begin
        wdog_cnt <= wdog_cnt - 10'd1;
      end
      if (wdog_fire) begin
        sched_err <= 1'b1;
      end
    end
  end
`else
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= CMD_RD;
      cmd_req    <= 1'b0;
      cmd_wr     <= 1'b0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
      busy       <= 1'b0;
    end else if (!sdram_init_done) begin
      state   <= IDLE;
      cmd_req <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            cmd_wr   <= grant_wr;
            cmd_addr <= grant_wr ? wr_ptr : rd_ptr;
            cmd_len  <= grant_wr ? wr_length : rd_length;
            cmd_req  <= 1'b1;
            busy     <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          // cmd_done alongside cmd_ack is deliberately ignored here.
          if (cmd_ack) begin
            cmd_req    <= 1'b0;
            last_grant <= cmd_wr;
            state      <= WAIT;
          end else if (wdog_fire) begin
            cmd_req <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        WAIT: begin
          if (cmd_done || wdog_fire) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          cmd_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  sdram_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr_addr (
    .clk_ref    (clk_ref),
    .rst        (rst),
    .track      (!sdram_init_done),
    .load       (wr_load),
    .advance    (wr_adv),
    .start_addr (wr_addr),
    .max_addr   (wr_max_addr),
    .len        (cmd_len),
    .ptr        (wr_ptr),
    .frame_done (frame_write_done)
  );

  sdram_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd_addr (
    .clk_ref    (clk_ref),
    .rst        (rst),
    .track      (!sdram_init_done),
    .load       (rd_load),
    .advance    (rd_adv),
    .start_addr (rd_addr),
    .max_addr   (rd_max_addr),
    .len        (cmd_len),
    .ptr        (rd_ptr),
    .frame_done (frame_read_done)
  );

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Self-checking bench for sdram_burst_sched. The bench plays the SDRAM
// command engine and keeps its own model of both pointers and the
// round-robin history. Build with SDRAM_SCHED_WDOG_EN to also cover the
// watchdog.
module tb_sdram_burst_sched;

  localparam int AW = 22;
  localparam int LW = 9;
  localparam int VW = 10;
  localparam int FRAME   = 130560;
  localparam int RD_BASE = 22'h200000;

  logic          clk_ref = 1'b0;
  logic          rst;
  logic          sdram_init_done;
  logic [VW-1:0] wr_fifo_usedw, rd_fifo_usedw;
  logic          rd_enable;
  logic [LW-1:0] wr_length, rd_length;
  logic [AW-1:0] wr_addr, rd_addr, wr_max_addr, rd_max_addr;
  logic          wr_load, rd_load;
  logic          cmd_req, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_ack, cmd_done;
  logic          frame_write_done, frame_read_done, busy;
`ifdef SDRAM_SCHED_WDOG_EN
  logic          sched_err;
`endif

  always #5 clk_ref = ~clk_ref;

  sdram_burst_sched dut (
    .clk_ref          (clk_ref),
    .rst              (rst),
    .sdram_init_done  (sdram_init_done),
    .wr_fifo_usedw    (wr_fifo_usedw),
    .rd_fifo_usedw    (rd_fifo_usedw),
    .rd_enable        (rd_enable),
    .wr_length        (wr_length),
    .rd_length        (rd_length),
    .wr_addr          (wr_addr),
    .rd_addr          (rd_addr),
    .wr_max_addr      (wr_max_addr),
    .rd_max_addr      (rd_max_addr),
    .wr_load          (wr_load),
    .rd_load          (rd_load),
    .cmd_req          (cmd_req),
    .cmd_wr           (cmd_wr),
    .cmd_addr         (cmd_addr),
    .cmd_len          (cmd_len),
    .cmd_ack          (cmd_ack),
    .cmd_done         (cmd_done),
    .frame_write_done (frame_write_done),
    .frame_read_done  (frame_read_done),
    .busy             (busy)
`ifdef SDRAM_SCHED_WDOG_EN
    ,
    .sched_err        (sched_err)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_wr_ptr, m_rd_ptr;
  bit m_last_wr;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_ref);
  endtask

  // -1 none, 1 write, 0 read, straight from the eligibility rules
  function automatic int exp_dir();
    bit we, re;
    we = (wr_length != 0) && (int'(wr_fifo_usedw) >= int'(wr_length));
    re = rd_enable && (rd_length != 0) && (int'(rd_fifo_usedw) < int'(rd_length));
    if (we && re) return m_last_wr ? 0 : 1;
    if (we) return 1;
    if (re) return 0;
    return -1;
  endfunction

  task automatic check_quiet_outputs(input string tag);
    check_eq({tag, "_req"},  cmd_req, 0);
    check_eq({tag, "_wr"},   cmd_wr, 0);
    check_eq({tag, "_addr"}, cmd_addr, 0);
    check_eq({tag, "_len"},  cmd_len, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_fwd"},  frame_write_done, 0);
    check_eq({tag, "_frd"},  frame_read_done, 0);
  endtask

  task automatic make_ineligible();
    wr_fifo_usedw = 0;
    rd_enable     = 0;
  endtask

  // DUT must be idle; reload both pointers to their start addresses.
  task automatic sync_ptrs();
    make_ineligible();
    wr_load = 1; rd_load = 1;
    tick();
    wr_load = 0; rd_load = 0;
    m_wr_ptr = wr_addr;
    m_rd_ptr = rd_addr;
  endtask

  // Called at a negedge with the DUT idle and stimulus already set.
  task automatic run_burst(input int ack_dly, input int done_dly,
                           input bit ack_with_done, input bit load_at_done,
                           output bit wr_pulse);
    int dir, exp_addr, exp_len, n, nxt, st, mx;
    bit exp_pulse;
    wr_pulse = 0;
    dir = exp_dir();
    if (dir < 0) return;
    exp_addr = (dir == 1) ? m_wr_ptr : m_rd_ptr;
    exp_len  = (dir == 1) ? int'(wr_length) : int'(rd_length);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cmd_req && n < 4);
    check_eq("req_latency", n, 1);
    if (!cmd_req) return;
    check_eq("cmd_wr", cmd_wr, dir);
    check_eq("cmd_addr", cmd_addr, exp_addr);
    check_eq("cmd_len", cmd_len, exp_len);
    check_eq("busy_req", busy, 1);
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      check_eq("hold_req", cmd_req, 1);
      check_eq("hold_addr", cmd_addr, exp_addr);
      check_eq("hold_len", cmd_len, exp_len);
    end
    cmd_ack = 1; cmd_done = ack_with_done;
    tick();
    cmd_ack = 0; cmd_done = 0;
    m_last_wr = (dir == 1);
    check_eq("req_drop", cmd_req, 0);
    check_eq("busy_wait", busy, 1);
    check_eq("ack_no_pulse", frame_write_done | frame_read_done, 0);
    for (int i = 0; i < done_dly; i++) begin
      tick();
      check_eq("busy_hold", busy, 1);
    end
    cmd_done = 1;
    if (load_at_done) begin
      if (dir == 1) wr_load = 1; else rd_load = 1;
    end
    tick();
    cmd_done = 0; wr_load = 0; rd_load = 0;
    st = (dir == 1) ? int'(wr_addr) : int'(rd_addr);
    mx = (dir == 1) ? int'(wr_max_addr) : int'(rd_max_addr);
    exp_pulse = 0;
    if (load_at_done) begin
      nxt = st;
    end else begin
      nxt = exp_addr + exp_len;
      if (nxt >= mx) begin
        nxt = st;
        exp_pulse = 1;
      end
    end
    if (dir == 1) m_wr_ptr = nxt; else m_rd_ptr = nxt;
    check_eq("frame_wr_done", frame_write_done, (dir == 1) && exp_pulse);
    check_eq("frame_rd_done", frame_read_done, (dir == 0) && exp_pulse);
    check_eq("busy_done", busy, 0);
    wr_pulse = frame_write_done;
  endtask

  initial begin
    int hi, pulses, pulse_at;
    bit p;
    rst = 1; sdram_init_done = 0;
    cmd_ack = 0; cmd_done = 0; wr_load = 0; rd_load = 0;
    wr_fifo_usedw = 300; rd_fifo_usedw = 0; rd_enable = 1;
    wr_length = 256; rd_length = 256;
    wr_addr = 0; wr_max_addr = FRAME;
    rd_addr = RD_BASE; rd_max_addr = RD_BASE + FRAME;

    // reset state
    repeat (3) tick();
    check_quiet_outputs("reset");
`ifdef SDRAM_SCHED_WDOG_EN
    check_eq("reset_err", sched_err, 0);
`endif
    rst = 0;
    m_last_wr = 0;

    // init gating: write has data but init is still pending
    hi = 0;
    repeat (50) begin
      tick();
      if (cmd_req) hi++;
    end
    check_eq("init_gate", hi, 0);
    sdram_init_done = 1;
    m_wr_ptr = wr_addr;
    m_rd_ptr = rd_addr;

    // round-robin: both eligible, last grant was read -> write, then read
    run_burst(0, 1, 0, 0, p);
    run_burst(2, 0, 0, 0, p);
    // handshake hold for 7 cycles
    run_burst(7, 3, 0, 0, p);

    // reset in the middle of WAIT
    wr_fifo_usedw = 300; rd_enable = 0;
    tick();
    check_eq("rstw_req", cmd_req, 1);
    cmd_ack = 1;
    tick();
    cmd_ack = 0;
    check_eq("rstw_busy", busy, 1);
    rst = 1;
    tick();
    check_quiet_outputs("rst_wait");
    make_ineligible();
    rst = 0;
    m_wr_ptr = 0; m_rd_ptr = 0; m_last_wr = 0;
    sync_ptrs();

    // frame wrap: 510 write bursts of 256 over 130560 words
    wr_fifo_usedw = 300; rd_enable = 0; wr_length = 256;
    pulses = 0; pulse_at = 0;
    for (int b = 1; b <= 510; b++) begin
      run_burst(0, 0, 0, 0, p);
      if (p) begin
        pulses++;
        pulse_at = b;
      end
    end
    check_eq("wrap_pulses", pulses, 1);
    check_eq("wrap_at", pulse_at, 510);
    check_eq("wrap_ptr_model", m_wr_ptr, 0);

    // load coincident with cmd_done at pointer 130304
    for (int b = 1; b <= 509; b++) run_burst(0, 0, 0, 0, p);
    check_eq("pre_load_ptr", m_wr_ptr, 130304);
    wr_addr = 4096;
    run_burst(0, 0, 0, 1, p);
    check_eq("load_no_pulse", p, 0);
    run_burst(0, 0, 0, 0, p);  // cmd_addr compared against 4096 here

`ifdef SDRAM_SCHED_WDOG_EN
    // withhold cmd_done: watchdog abandons after 1023 busy cycles
    begin
      int bc, guard;
      wr_fifo_usedw = 300; rd_enable = 0;
      tick();
      check_eq("wd_req", cmd_req, 1);
      check_eq("wd_addr", cmd_addr, m_wr_ptr);
      cmd_ack = 1;
      bc = 1; guard = 0;
      do begin
        tick();
        cmd_ack = 0;
        guard++;
        if (busy) bc++;
      end while (busy && guard < 1100);
      check_eq("wd_cycles", bc, 1023);
      check_eq("wd_req_drop", cmd_req, 0);
      check_eq("wd_err", sched_err, 1);
      m_last_wr = 1;
      run_burst(0, 0, 0, 0, p);  // retried at the same address
      check_eq("wd_err_sticky", sched_err, 1);
    end
`endif

    // randomized traffic with short frames to exercise wrapping
    wr_addr     = $urandom_range(0, 100000);
    wr_max_addr = wr_addr + $urandom_range(600, 3000);
    rd_addr     = RD_BASE + $urandom_range(0, 100000);
    rd_max_addr = rd_addr + $urandom_range(600, 3000);
    sync_ptrs();
    for (int it = 0; it < 300; it++) begin
      wr_length     = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 256);
      rd_length     = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 256);
      wr_fifo_usedw = $urandom_range(0, 400);
      rd_fifo_usedw = $urandom_range(0, 400);
      rd_enable     = ($urandom_range(0, 3) != 0);
      if (exp_dir() < 0) begin
        // stray handshakes while idle must be ignored
        cmd_ack = 1; cmd_done = 1;
        tick();
        cmd_ack = 0; cmd_done = 0;
        check_eq("idle_req", cmd_req, 0);
        check_eq("idle_pulse", frame_write_done | frame_read_done, 0);
        tick();
        check_eq("idle_req2", cmd_req, 0);
      end else begin
        run_burst($urandom_range(0, 4), $urandom_range(0, 4),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), p);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
